// File: rtl/dm_store_buffer_if.sv
// Bus bundle between the pipeline store/load path, the store buffer and the
// data memory write port. The buffer sits on the slave side; whoever drives
// stores, loads and the dm hold uses the master side.
interface dm_store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // pipeline store side
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_pc;
  logic [AW-1:0] st_addr;
  logic [AW-1:0] st_data;

  // pipeline load lookup side
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [AW-1:0] ld_data;

  // data memory write port side
  logic          dm_hold;
  logic          DMWr;
  logic [AW-1:0] dm_pc;
  logic [AW-1:0] dm_A;
  logic [AW-1:0] dm_WD;

  // occupancy status
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_pc, st_addr, st_data, ld_addr, dm_hold,
    input  st_ready, ld_hit, ld_data, DMWr, dm_pc, dm_A, dm_WD, empty, count
  );

  modport slave (
    input  st_valid, st_pc, st_addr, st_data, ld_addr, dm_hold,
    output st_ready, ld_hit, ld_data, DMWr, dm_pc, dm_A, dm_WD, empty, count
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer in front of the data memory write port.
// Stores are queued in a small circular buffer and drained in order, one per
// cycle, whenever dm is not holding. Loads look up the buffer by word address
// and get the youngest matching store so they stay coherent with pending writes.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic               clk,
  input logic               reset,
  dm_store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] addr;
    logic [AW-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        entry_d;
  entry_t        head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;
  logic          not_empty;
  logic [PW-1:0] fwd_idx;

  // Handshake and drain outputs; a full buffer refuses even if it pops this cycle
  always_comb begin
    not_empty    = (count_q != '0);
    push         = bus.st_valid & (count_q != FULL);
    pop          = not_empty & ~bus.dm_hold;
    head         = mem_q[rd_ptr_q];
    entry_d      = '{pc: bus.st_pc, addr: bus.st_addr, data: bus.st_data};

    bus.st_ready = (count_q != FULL);
    bus.DMWr     = pop;
    bus.dm_pc    = not_empty ? head.pc   : '0;
    bus.dm_A     = not_empty ? head.addr : '0;
    bus.dm_WD    = not_empty ? head.data : '0;
    bus.empty    = ~not_empty;
    bus.count    = count_q;
  end

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Load forwarding: walk entries oldest to youngest so the youngest match wins
  always_comb begin
    bus.ld_hit  = 1'b0;
    bus.ld_data = '0;
    fwd_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) &&
          (((bus.ld_addr ^ mem_q[fwd_idx].addr) & WORD_MASK) == '0)) begin
        bus.ld_hit  = 1'b1;
        bus.ld_data = mem_q[fwd_idx].data;
      end
    end
  end

  // Pointer and occupancy registers; reset discards every held entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful inside the rd_ptr/count window
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: reset, single store latency, fill and
// ordered drain, word-granular forwarding, steady push/pop with wrap, and
// asynchronous reset with entries held.
module tb_dm_store_buffer;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  dm_store_buffer_if #(.DEPTH(4), .AW(32)) bus ();

  dm_store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive all inputs for this cycle, then let the combinational outputs settle
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic hold, input logic [31:0] ld);
    bus.st_valid = valid;
    bus.st_pc    = pc;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.dm_hold  = hold;
    bus.ld_addr  = ld;
    #1;
  endtask

  // one comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // reset state
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_st_ready", 32'(bus.st_ready), 32'd1);
    checkOutput("rst_empty",    32'(bus.empty),    32'd1);
    checkOutput("rst_DMWr",     32'(bus.DMWr),     32'd0);
    checkOutput("rst_ld_hit",   32'(bus.ld_hit),   32'd0);
    checkOutput("rst_ld_data",  bus.ld_data,       32'h0);
    checkOutput("rst_dm_A",     bus.dm_A,          32'h0);
    checkOutput("rst_dm_pc",    bus.dm_pc,         32'h0);
    checkOutput("rst_dm_WD",    bus.dm_WD,         32'h0);
    checkOutput("rst_count",    32'(bus.count),    32'd0);
    reset = 1'b1;
    tick();

    // single store: accepted at edge 1, on DMWr in the following cycle
    $display("[TB] single store latency");
    applyStimulus(1'b1, 32'h3000, 32'h10, 32'hAA, 1'b0, 32'h10);
    checkOutput("t2_st_ready",  32'(bus.st_ready), 32'd1);
    checkOutput("t2_no_bypass", 32'(bus.DMWr),     32'd0);
    checkOutput("t2_push_nofwd",32'(bus.ld_hit),   32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h10);
    checkOutput("t2_DMWr",      32'(bus.DMWr),     32'd1);
    checkOutput("t2_dm_A",      bus.dm_A,          32'h10);
    checkOutput("t2_dm_WD",     bus.dm_WD,         32'hAA);
    checkOutput("t2_dm_pc",     bus.dm_pc,         32'h3000);
    checkOutput("t2_count",     32'(bus.count),    32'd1);
    checkOutput("t6_pop_fwd_hit",  32'(bus.ld_hit), 32'd1);
    checkOutput("t6_pop_fwd_data", bus.ld_data,     32'hAA);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h10);
    checkOutput("t2_empty",     32'(bus.empty),    32'd1);
    checkOutput("t2_DMWr_off",  32'(bus.DMWr),     32'd0);
    checkOutput("t6_after_hit", 32'(bus.ld_hit),   32'd0);
    checkOutput("t6_after_data",bus.ld_data,       32'h0);
    checkOutput("t2_dm_A_zero", bus.dm_A,          32'h0);

    // fill under hold, refuse a fifth store, then drain in order
    $display("[TB] fill and ordered drain");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h4000 + 32'(4 * i), 32'(4 * i), 32'h100 + 32'(i), 1'b1, 32'h0);
      tick();
    end
    applyStimulus(1'b1, 32'h4010, 32'h50, 32'h1FF, 1'b1, 32'h0);
    checkOutput("t3_full_count", 32'(bus.count),    32'd4);
    checkOutput("t3_full_ready", 32'(bus.st_ready), 32'd0);
    checkOutput("t3_hold_DMWr",  32'(bus.DMWr),     32'd0);
    tick();
    applyStimulus(1'b1, 32'h4010, 32'h50, 32'h1FF, 1'b0, 32'h0);
    checkOutput("t3_5th_ignored", 32'(bus.count),    32'd4);
    checkOutput("t3_full_pop_rdy",32'(bus.st_ready), 32'd0);
    checkOutput("t3_drain0_DMWr", 32'(bus.DMWr),     32'd1);
    checkOutput("t3_drain0_A",    bus.dm_A,          32'h0);
    checkOutput("t3_drain0_WD",   bus.dm_WD,         32'h100);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t3_no_bypass_cnt", 32'(bus.count),    32'd3);
    checkOutput("t3_ready_again",   32'(bus.st_ready), 32'd1);
    checkOutput("t3_drain1_A",      bus.dm_A,          32'h4);
    checkOutput("t3_drain1_pc",     bus.dm_pc,         32'h4004);
    tick();
    for (int i = 2; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("t3_drain_DMWr", 32'(bus.DMWr), 32'd1);
      checkOutput("t3_drain_A",    bus.dm_A,      32'(4 * i));
      checkOutput("t3_drain_WD",   bus.dm_WD,     32'h100 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t3_empty", 32'(bus.empty), 32'd1);
    checkOutput("t3_idle",  32'(bus.DMWr),  32'd0);

    // forwarding: word compare, youngest wins, same-cycle push not visible
    $display("[TB] load forwarding");
    applyStimulus(1'b1, 32'h5000, 32'h20, 32'h1, 1'b1, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h5004, 32'h22, 32'h2, 1'b1, 32'h20);
    checkOutput("t4_old_hit",  32'(bus.ld_hit), 32'd1);
    checkOutput("t4_old_data", bus.ld_data,     32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h20);
    checkOutput("t4_young_hit",  32'(bus.ld_hit), 32'd1);
    checkOutput("t4_young_data", bus.ld_data,     32'h2);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h23);
    checkOutput("t4_offset_hit",  32'(bus.ld_hit), 32'd1);
    checkOutput("t4_offset_data", bus.ld_data,     32'h2);
    applyStimulus(1'b1, 32'h5008, 32'h24, 32'h9, 1'b1, 32'h24);
    checkOutput("t4_miss_hit",  32'(bus.ld_hit), 32'd0);
    checkOutput("t4_miss_data", bus.ld_data,     32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h24);
    checkOutput("t4_new_hit",   32'(bus.ld_hit), 32'd1);
    checkOutput("t4_new_data",  bus.ld_data,     32'h9);
    checkOutput("t4_count",     32'(bus.count),  32'd3);
    checkOutput("t4_head_held", bus.dm_A,        32'h20);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t4_drain0_A", bus.dm_A, 32'h20);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t4_drain1_A",  bus.dm_A,  32'h22);
    checkOutput("t4_drain1_WD", bus.dm_WD, 32'h2);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t4_drain2_A", bus.dm_A, 32'h24);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t4_empty", 32'(bus.empty), 32'd1);

    // steady state at DEPTH-1 with push and pop every cycle, pointers wrap
    $display("[TB] steady push/pop");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h6000 + 32'(k), 32'h100 + 32'(4 * k), 32'h700 + 32'(k), 1'b1, 32'h0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h6000 + 32'(i + 3), 32'h10C + 32'(4 * i), 32'h703 + 32'(i), 1'b0, 32'h0);
      checkOutput("t5_count", 32'(bus.count),    32'd3);
      checkOutput("t5_ready", 32'(bus.st_ready), 32'd1);
      checkOutput("t5_DMWr",  32'(bus.DMWr),     32'd1);
      checkOutput("t5_dm_A",  bus.dm_A,          32'h100 + 32'(4 * i));
      checkOutput("t5_dm_WD", bus.dm_WD,         32'h700 + 32'(i));
      tick();
    end
    for (int i = 10; i < 13; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("t5_tail_A", bus.dm_A, 32'h100 + 32'(4 * i));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t5_empty", 32'(bus.empty), 32'd1);

    // asynchronous reset with three entries held
    $display("[TB] reset with entries held");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h7000, 32'h200 + 32'(4 * k), 32'h800 + 32'(k), 1'b1, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h200);
    checkOutput("t1_held_count", 32'(bus.count),  32'd3);
    checkOutput("t1_held_hit",   32'(bus.ld_hit), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t1_async_count", 32'(bus.count),    32'd0);
    checkOutput("t1_async_DMWr",  32'(bus.DMWr),     32'd0);
    checkOutput("t1_async_hit",   32'(bus.ld_hit),   32'd0);
    tick();
    checkOutput("t1_count",    32'(bus.count),    32'd0);
    checkOutput("t1_empty",    32'(bus.empty),    32'd1);
    checkOutput("t1_DMWr",     32'(bus.DMWr),     32'd0);
    checkOutput("t1_st_ready", 32'(bus.st_ready), 32'd1);
    checkOutput("t1_dm_A",     bus.dm_A,          32'h0);
    reset = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h200);
    checkOutput("t1_stale_hit",  32'(bus.ld_hit), 32'd0);
    checkOutput("t1_stale_data", bus.ld_data,     32'h0);
    checkOutput("t1_post_DMWr",  32'(bus.DMWr),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
